// File: rtl/serial_mag_comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, 2-bit digit
// results and the digit width consumed per cycle.
package cmp_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef enum logic [1:0] {
    EQ = 2'b00,
    GT = 2'b01,
    LT = 2'b10
  } digit_res_t;

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Request/result bundle between a requester and the serial comparator.
interface serial_mag_comparator_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic             agb;
  logic             alb;
  logic             aeb;

  modport master (output start, a, b, input ready, done, agb, alb, aeb);
  modport slave  (input start, a, b, output ready, done, agb, alb, aeb);
endinterface

// File: rtl/serial_mag_comparator_digit_slice.sv
// Combinational 2-bit unsigned comparator returning GT/LT/EQ.
module cmp_digit_slice
  import cmp_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  output digit_res_t         res_o
);
  always_comb begin
    res_o = EQ;
    if (a_i > b_i)      res_o = GT;
    else if (a_i < b_i) res_o = LT;
  end
endmodule

// File: rtl/serial_mag_comparator.sv
// MSB-first serial magnitude comparator, one 2-bit digit per cycle.
// Optional SERIAL_CMP_EARLY_EXIT_EN finishes on the first differing digit.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_mag_comparator_if.slave bus
);
  localparam int unsigned D     = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W = $clog2(D + 1);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_res_t       dec_q, dec_d;
  logic             agb_q, agb_d, alb_q, alb_d, aeb_q, aeb_d;
  digit_res_t       slice_res;
  digit_res_t       dec_nxt;
  logic             last;

  cmp_digit_slice u_slice (
    .a_i  (sa_q[WIDTH-1 -: DIGIT_W]),
    .b_i  (sb_q[WIDTH-1 -: DIGIT_W]),
    .res_o(slice_res)
  );

  // The decision freezes on the first non-EQ digit.
  assign dec_nxt = (dec_q == EQ) ? slice_res : dec_q;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    agb_d   = agb_q;
    alb_d   = alb_q;
    aeb_d   = aeb_q;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          cnt_d   = CNT_W'(D);
          dec_d   = EQ;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q << DIGIT_W;
        sb_d  = sb_q << DIGIT_W;
        cnt_d = cnt_q - 1'b1;
        dec_d = dec_nxt;
        last  = (cnt_q == CNT_W'(1));
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (dec_q == EQ && slice_res != EQ) last = 1'b1;
`endif
        if (last) begin
          state_d = DONE;
          agb_d   = (dec_nxt == GT);
          alb_d   = (dec_nxt == LT);
          aeb_d   = (dec_nxt == EQ);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      dec_q   <= EQ;
      agb_q   <= 1'b0;
      alb_q   <= 1'b0;
      aeb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      agb_q   <= agb_d;
      alb_q   <= alb_d;
      aeb_q   <= aeb_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.agb   = agb_q;
  assign bus.alb   = alb_q;
  assign bus.aeb   = aeb_q;
endmodule
